// File: rtl/alu_datapath.sv
// alu_datapath: bus ALU with operand/result registers and a sequencing FSM.
// Define ALU_FLAGS_EN to build the flag_z/flag_c/flag_n outputs.
module alu_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [3:0]       opcode,
    input  logic             ALUin0,
    input  logic             ALUin1,
    input  logic             ALUoutlatch,
    input  logic             ALUoutEN,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             result_valid,
    output logic             seq_err
`ifdef ALU_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_A_RDY  = 2'd1,
        S_AB_RDY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             load_a;
    logic             load_b;
    logic             op_ok;
    logic             latch_ok;
    logic             err_set;
    logic             have_a;
    logic [WIDTH-1:0] alu_res;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: operand capture wins over a coincident latch
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            load_a && load_b:
                state_d = S_AB_RDY;
            load_a && !load_b:
                state_d = S_A_RDY;
            !load_a && load_b && have_a:
                state_d = S_AB_RDY;
            !load_a && !load_b && latch_ok:
                state_d = S_DONE;
            default:
                state_d = state_q;
        endcase
    end

    // Strobe decode against the pre-edge state
    always_comb begin
        have_a   = (state_q == S_A_RDY) || (state_q == S_AB_RDY);
        op_ok    = opcode[3] && (opcode[2:0] != 3'b000);
        load_a   = ALUin0;
        load_b   = ALUin1;
        latch_ok = ALUoutlatch && (state_q == S_AB_RDY) && op_ok;
        err_set  = (ALUoutlatch && !latch_ok)
                 || (ALUin1 && !ALUin0 && !have_a);
    end

    always_comb begin
        alu_res = '0;
        case (opcode)
            4'b1001: alu_res = a_q + b_q;
            4'b1010: alu_res = a_q - b_q;
            4'b1011: alu_res = a_q & b_q;
            4'b1100: alu_res = a_q | b_q;
            4'b1101: alu_res = a_q ^ b_q;
            4'b1110: alu_res = ~a_q;
            4'b1111: alu_res = a_q << 1;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        a_d      = load_a ? bus_in : a_q;
        b_d      = load_b ? bus_in : b_q;
        result_d = latch_ok ? alu_res : result_q;
        err_d    = err_q | err_set;
        valid_d  = valid_q;
        if (load_a) begin
            valid_d = 1'b0;
        end else if (latch_ok) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign bus_oe       = ALUoutEN;
    assign bus_out      = ALUoutEN ? result_q : '0;
    assign result_valid = valid_q;
    assign seq_err      = err_q;

`ifdef ALU_FLAGS_EN
    logic alu_c;
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;
    logic flag_n_q, flag_n_d;
    logic [WIDTH:0] add_wide;

    always_comb begin
        add_wide = {1'b0, a_q} + {1'b0, b_q};
        case (opcode)
            4'b1001: alu_c = add_wide[WIDTH];
            4'b1010: alu_c = (a_q < b_q);
            4'b1111: alu_c = a_q[WIDTH-1];
            default: alu_c = 1'b0;
        endcase
    end

    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_n_d = flag_n_q;
        if (latch_ok) begin
            flag_z_d = (alu_res == '0);
            flag_c_d = alu_c;
            flag_n_d = alu_res[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
    assign flag_n = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed scenarios plus random strobes against a
// behavioural model of the bus ALU.
module tb_alu_datapath;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] bus_in;
    logic [3:0]   opcode;
    logic         in0, in1, lat, en;
    logic [W-1:0] bus_out;
    logic         bus_oe, result_valid, seq_err;
`ifdef ALU_FLAGS_EN
    logic         flag_z, flag_c, flag_n;
`endif

    int total = 0;
    int bad = 0;

    // Model: phase 0=idle 1=have A 2=have A,B 3=done
    logic [W-1:0] m_a, m_b, m_res;
    logic         m_rv, m_err, m_z, m_c, m_n;
    int           m_ph;

    alu_datapath #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus_in(bus_in),
        .opcode(opcode),
        .ALUin0(in0),
        .ALUin1(in1),
        .ALUoutlatch(lat),
        .ALUoutEN(en),
        .bus_out(bus_out),
        .bus_oe(bus_oe),
        .result_valid(result_valid),
        .seq_err(seq_err)
`ifdef ALU_FLAGS_EN
        ,
        .flag_z(flag_z),
        .flag_c(flag_c),
        .flag_n(flag_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_a = '0; m_b = '0; m_res = '0;
        m_rv = 0; m_err = 0;
        m_z = 0; m_c = 0; m_n = 0;
        m_ph = 0;
    endtask

    task automatic model_edge();
        bit ok;
        int ia, ib, s;
        ia = int'(m_a);
        ib = int'(m_b);
        ok = lat && m_ph == 2 && opcode >= 4'd9;
        if (lat && !ok) m_err = 1;
        if (in1 && !in0 && (m_ph == 0 || m_ph == 3)) m_err = 1;
        if (ok) begin
            m_c = 0;
            case (int'(opcode))
                9: begin s = ia + ib; m_c = (s >= 65536); end
                10: begin s = ia - ib; m_c = (ia < ib); end
                11: s = ia & ib;
                12: s = ia | ib;
                13: s = ia ^ ib;
                14: s = 65535 - ia;
                default: begin s = ia * 2; m_c = (ia >= 32768); end
            endcase
            m_res = W'(s);
            m_rv = 1;
            m_z = (m_res == 0);
            m_n = (m_res >= 16'h8000);
        end
        if (in0 && in1) m_ph = 2;
        else if (in0) m_ph = 1;
        else if (in1 && (m_ph == 1 || m_ph == 2)) m_ph = 2;
        else if (ok) m_ph = 3;
        if (in0) begin m_a = bus_in; m_rv = 0; end
        if (in1) m_b = bus_in;
    endtask

    task automatic step(input bit i0, input bit i1, input bit l,
                        input bit e, input logic [W-1:0] b,
                        input logic [3:0] op);
        in0 = i0; in1 = i1; lat = l; en = e;
        bus_in = b; opcode = op;
        @(posedge clk);
        model_edge();
        #1;
        in0 = 0; in1 = 0; lat = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 16'h1234, 4'd0);
        step(0, 1, 0, 0, 16'h0001, 4'd0);
        @(negedge clk);
        rst = 1; en = 1;
        #1;
        total++;
        if ({bus_out, bus_oe, result_valid, seq_err} !== {16'h0, 3'b100}) begin
            bad++;
            $display("FAIL reset_en: got %h/%b%b%b want 0000/100",
                     bus_out, bus_oe, result_valid, seq_err);
        end
        en = 0;
        #1;
        total++;
        if ({bus_out, bus_oe} !== {16'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_oe: got %h/%b want 0000/0", bus_out, bus_oe);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_add();
        do_reset();
        step(1, 0, 0, 0, 16'h0005, 4'd0);
        step(0, 1, 0, 0, 16'h0003, 4'd0);
        step(0, 0, 1, 0, 16'h0000, 4'b1001);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 16'hAAAA, 4'd0);
            total++;
            if ({bus_out, bus_oe, result_valid, seq_err} !== {16'h0008, 3'b110}) begin
                bad++;
                $display("FAIL add_read%0d: got %h/%b%b%b want 0008/110",
                         i, bus_out, bus_oe, result_valid, seq_err);
            end
        end
    endtask

    task automatic test_add_wrap();
        do_reset();
        step(1, 0, 0, 0, 16'hFFFF, 4'd0);
        step(0, 1, 0, 0, 16'h0001, 4'd0);
        step(0, 0, 1, 1, 16'h0000, 4'b1001);
        total++;
        if ({bus_out, result_valid} !== {16'h0000, 1'b1}) begin
            bad++;
            $display("FAIL add_wrap: got %h/%b want 0000/1", bus_out, result_valid);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if ({flag_z, flag_c, flag_n} !== 3'b110) begin
            bad++;
            $display("FAIL add_flags: got %b%b%b want 110", flag_z, flag_c, flag_n);
        end
`endif
    endtask

    task automatic test_sub();
        do_reset();
        step(1, 0, 0, 0, 16'h0002, 4'd0);
        step(0, 1, 0, 0, 16'h0005, 4'd0);
        step(0, 0, 1, 1, 16'h0000, 4'b1010);
        total++;
        if (bus_out !== 16'hFFFD) begin
            bad++;
            $display("FAIL sub: got %h want fffd", bus_out);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if ({flag_z, flag_c, flag_n} !== 3'b011) begin
            bad++;
            $display("FAIL sub_flags: got %b%b%b want 011", flag_z, flag_c, flag_n);
        end
`endif
    endtask

    task automatic test_early_latch();
        do_reset();
        step(1, 0, 0, 0, 16'h0007, 4'd0);
        step(0, 0, 1, 1, 16'h0000, 4'b1001);
        total++;
        if ({bus_out, result_valid, seq_err} !== {16'h0000, 2'b01}) begin
            bad++;
            $display("FAIL early_latch: got %h/%b%b want 0000/01",
                     bus_out, result_valid, seq_err);
        end
        step(0, 1, 0, 0, 16'h0002, 4'd0);
        step(0, 0, 1, 1, 16'h0000, 4'b1001);
        total++;
        if ({bus_out, result_valid, seq_err} !== {16'h0009, 2'b11}) begin
            bad++;
            $display("FAIL sticky_err: got %h/%b%b want 0009/11",
                     bus_out, result_valid, seq_err);
        end
    endtask

    task automatic test_same_bus();
        do_reset();
        step(1, 1, 0, 0, 16'h00F0, 4'd0);
        step(0, 0, 1, 1, 16'h0000, 4'b1101);
        total++;
        if ({bus_out, result_valid, seq_err} !== {16'h0000, 2'b10}) begin
            bad++;
            $display("FAIL same_bus: got %h/%b%b want 0000/10",
                     bus_out, result_valid, seq_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 0, 0, 0, 16'h0011, 4'd0);
        step(0, 1, 0, 0, 16'h0022, 4'd0);
        do_reset();
        step(0, 0, 1, 1, 16'h0000, 4'b1001);
        total++;
        if ({bus_out, bus_oe, result_valid, seq_err} !== {16'h0000, 3'b101}) begin
            bad++;
            $display("FAIL reset_mid: got %h/%b%b%b want 0000/101",
                     bus_out, bus_oe, result_valid, seq_err);
        end
    endtask

    task automatic test_random();
        bit i0, i1, l, e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            i0 = ($urandom_range(0, 3) == 0);
            i1 = ($urandom_range(0, 2) == 0);
            l  = ($urandom_range(0, 2) == 0) && !i0;
            e  = $urandom_range(0, 1) == 1;
            step(i0, i1, l, e, 16'($urandom),
                 (($urandom_range(0, 4) == 0) ? 4'($urandom)
                                              : 4'($urandom_range(9, 15))));
            total++;
            if ({bus_out, bus_oe, result_valid, seq_err}
                !== {(e ? m_res : 16'h0), e, m_rv, m_err}) begin
                bad++;
                $display("FAIL rand%0d: got %h/%b%b%b want %h/%b%b%b", i,
                         bus_out, bus_oe, result_valid, seq_err,
                         (e ? m_res : 16'h0), e, m_rv, m_err);
            end
`ifdef ALU_FLAGS_EN
            total++;
            if ({flag_z, flag_c, flag_n} !== {m_z, m_c, m_n}) begin
                bad++;
                $display("FAIL rand_flags%0d: got %b%b%b want %b%b%b", i,
                         flag_z, flag_c, flag_n, m_z, m_c, m_n);
            end
`endif
            if (i % 100 == 99) do_reset();
        end
    endtask

    initial begin
        rst = 1; in0 = 0; in1 = 0; lat = 0; en = 0;
        bus_in = '0; opcode = '0;
        model_reset();
        #12;
        rst = 0;
        test_reset();
        test_add();
        test_add_wrap();
        test_sub();
        test_early_latch();
        test_same_bus();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, which sets the operand, result and bus width in bits.
- REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
- REQ-004 SHALL have port bus_in, input, WIDTH bits: the shared data bus as driven by the general register selected by rxOut.
- REQ-005 SHALL have port opcode, input, 4 bits: instruction[15:12], sampled only in a cycle where ALUoutlatch is 1.
- REQ-006 SHALL have ports ALUin0, ALUin1, ALUoutlatch and ALUoutEN, each an input of 1 bit: the strobes issued by the ALU sequencer.
- REQ-007 SHALL have port bus_out, output, WIDTH bits: the result register value, or zero when ALUoutEN is 0.
- REQ-008 SHALL have port bus_oe, output, 1 bit: the bus drive enable, equal to ALUoutEN combinationally.
- REQ-009 SHALL have port result_valid, output, 1 bit: the result register holds a completed operation.
- REQ-010 SHALL have port seq_err, output, 1 bit: sticky protocol-violation flag.

Function
- REQ-011 SHALL implement a 4-state FSM: IDLE, A_RDY, AB_RDY, DONE.
- REQ-012 SHALL, when ALUin0=1 in any state, load operand A from bus_in and go to A_RDY. result_valid clears the same edge.
- REQ-013 SHALL, when ALUin1=1 in A_RDY or AB_RDY, load operand B from bus_in and go to AB_RDY.
- REQ-014 SHALL, when ALUin1=1 in IDLE or DONE (without ALUin0), still load B, set seq_err and leave the state unchanged.
- REQ-015 SHALL, when ALUin0 and ALUin1 are 1 in the same cycle, load A and B from the same bus_in value and go to AB_RDY.
- REQ-016 SHALL, when ALUoutlatch=1 in AB_RDY with opcode 1001-1111, write the result next edge, set result_valid=1 and go to DONE (1-cycle latency).
- REQ-017 SHALL use this opcode map:
  - 1001 A+B
  - 1010 A-B
  - 1011 A&B
  - 1100 A|B
  - 1101 A^B
  - 1110 ~A
  - 1111 A<<1
  - all results truncated to WIDTH, wrap-around with no saturation.
- REQ-018 SHALL, when ALUoutlatch=1 in any state other than AB_RDY, or with opcode 0000-1000, leave the result and result_valid unchanged, set seq_err and hold the state.
- REQ-019 SHALL, when ALUoutlatch coincides with ALUin0/ALUin1, evaluate the latch against the pre-edge state and operands. The operand capture determines the next state.
- REQ-020 SHALL have ALUoutEN read the result register only, without altering state. Repeated or held ALUoutEN cycles drive the same value.
- REQ-021 SHALL keep seq_err set once it is asserted until rst.

Reset
- REQ-022 SHALL, on rst=1, immediately set operands, result and flags to 0, result_valid=0, seq_err=0 and state IDLE, including mid-operation.
- REQ-023 SHALL keep bus_oe following ALUoutEN during reset, with bus_out=0.

Configuration
- REQ-024 SHALL, with ALU_FLAGS_EN defined, add outputs flag_z, flag_c and flag_n (each 1 bit), updated only on a successful latch:
  - z = result==0
  - c = carry-out for ADD, borrow (A<B unsigned) for SUB, A[WIDTH-1] for SHL, 0 otherwise
  - n = result[WIDTH-1]
- REQ-025 SHALL, without ALU_FLAGS_EN, omit those ports and their registers entirely, with the behaviour of all other ports unchanged.

Verification
- REQ-026 SHALL cover: ALUin0 with bus_in=0x0005, ALUin1 with 0x0003, ALUoutlatch with opcode 1001, then ALUoutEN -> bus_out=0x0008, bus_oe=1, result_valid=1, seq_err=0.
- REQ-027 SHALL cover: A=0xFFFF, B=0x0001, opcode 1001 -> result 0x0000; with flags, z=1, c=1, n=0.
- REQ-028 SHALL cover: A=0x0002, B=0x0005, opcode 1010 -> result 0xFFFD; with flags, c=1, n=1.
- REQ-029 SHALL cover: ALUoutlatch issued in A_RDY -> seq_err=1, result unchanged, state remains A_RDY; seq_err stays 1 through a later valid operation.
- REQ-030 SHALL cover: ALUin0 and ALUin1 together with bus_in=0x00F0, then opcode 1101 -> result 0x0000.
- REQ-031 SHALL cover: rst pulsed between ALUin1 and ALUoutlatch -> state IDLE; the following ALUoutlatch sets seq_err=1 and bus_out reads 0x0000.
